// File: rtl/match_slot_scheduler.sv
// match_slot_scheduler: round-robin sharing of the order-matching core between trader ports
module match_slot_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int IW      = $clog2(NUM_REQ),
   parameter int TIMEOUT = 15,
   parameter int TW      = 4
) (
   input  logic               slow_clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic               halt_signal,
   input  logic               match_done,
   input  logic               match_hit,
   output logic [NUM_REQ-1:0] grant,
   output logic               start,
   output logic [NUM_REQ-1:0] ack,
   output logic               enable_count,
   output logic               busy,
   output logic [IW-1:0]      last_winner,
   output logic               timeout_err
);

   typedef enum logic [1:0] {IDLE, WAIT, COMMIT, HALTED} state_t;

   state_t             state, state_n;
   logic [TW-1:0]      timer, timer_n;
   logic               hit, hit_n;
   logic [NUM_REQ-1:0] grant_n, ack_n;
   logic               start_n, enable_count_n, busy_n, timeout_err_n;
   logic [IW-1:0]      last_winner_n, winner, cand;
   logic               found;

   // first requester after the previous winner, wrapping around the ports
   always_comb begin
      winner = last_winner;
      cand   = last_winner;
      found  = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = IW'((int'(last_winner) + i) % NUM_REQ);
         if (!found && req[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   // next state and next values of every registered output
   always_comb begin
      state_n        = state;
      timer_n        = timer;
      hit_n          = hit;
      grant_n        = grant;
      start_n        = 1'b0;
      ack_n          = '0;
      enable_count_n = 1'b0;
      last_winner_n  = last_winner;
      timeout_err_n  = timeout_err;
      case (state)
         IDLE: begin
            if (halt_signal) begin
               state_n = HALTED;
            end else if (found) begin
               grant_n       = NUM_REQ'(1) << winner;
               start_n       = 1'b1;
               last_winner_n = winner;
               timer_n       = '0;
               state_n       = WAIT;
            end
         end
         WAIT: begin
            timer_n = timer + 1'b1;
            if (match_done) begin
               hit_n   = match_hit;
               state_n = COMMIT;
            end else if (timer == TW'(TIMEOUT - 1)) begin
               timeout_err_n = 1'b1;
               hit_n         = 1'b0;
               state_n       = COMMIT;
            end
         end
         COMMIT: begin
            ack_n          = grant;
            grant_n        = '0;
            enable_count_n = hit & ~halt_signal;
            state_n        = halt_signal ? HALTED : IDLE;
         end
         HALTED: begin
            grant_n = '0;
            state_n = halt_signal ? HALTED : IDLE;
         end
         default: begin
            grant_n = '0;
            state_n = IDLE;
         end
      endcase
      busy_n = (state_n == WAIT) || (state_n == COMMIT);
   end

   // state and output registers; reset aborts any transaction in flight
   always_ff @(posedge slow_clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         timer        <= '0;
         hit          <= 1'b0;
         grant        <= '0;
         start        <= 1'b0;
         ack          <= '0;
         enable_count <= 1'b0;
         busy         <= 1'b0;
         last_winner  <= IW'(NUM_REQ - 1);
         timeout_err  <= 1'b0;
      end else begin
         state        <= state_n;
         timer        <= timer_n;
         hit          <= hit_n;
         grant        <= grant_n;
         start        <= start_n;
         ack          <= ack_n;
         enable_count <= enable_count_n;
         busy         <= busy_n;
         last_winner  <= last_winner_n;
         timeout_err  <= timeout_err_n;
      end
   end

   a_grant_onehot: assert property (@(posedge slow_clk) disable iff (reset) $onehot0(grant));
   a_ack_pulse:    assert property (@(posedge slow_clk) disable iff (reset) |ack |=> ack == '0);
   a_count_on_ack: assert property (@(posedge slow_clk) disable iff (reset) enable_count |-> |ack);

endmodule

// File: doc/match_slot_scheduler.md
Name: match_slot_scheduler

Overview:
- Round-robin arbiter and sequencer that shares the single order-matching core between NUM_REQ trader ports.
- Grants one requester at a time, launches a match evaluation and waits for the core's result, with a timeout.
- Emits one enable_count pulse per completed trade to the trade counter.
- Stops issuing grants once the trade counter raises halt_signal.

Parameters:
- NUM_REQ, 4: number of trader ports; must be ≥2.
- IW, $clog2(NUM_REQ) (2 at default): index width.
- TIMEOUT, 15: max cycles to wait for match_done after start; must be ≥1.
- TW, 4: timer width; must satisfy 2^TW > TIMEOUT.

Ports:
- slow_clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clock slow_clk
- req  in  NUM_REQ  level request per port; held until that port's ack
- halt_signal  in  1  from trade counter; high = trade limit reached
- match_done  in  1  core finished evaluation (single-cycle pulse)
- match_hit  in  1  qualified by match_done; 1 = trade executed
- grant  out  NUM_REQ  one-hot owner of the matching core; all-zero when idle
- start  out  1  one-cycle pulse to core to begin evaluation
- ack  out  NUM_REQ  one-cycle pulse to granted port at transaction end
- enable_count  out  1  one-cycle pulse per trade, to trade counter
- busy  out  1  high in any state other than IDLE and HALTED
- last_winner  out  IW  index of most recently granted port
- timeout_err  out  1  sticky; set on any timeout, cleared only by reset

Behaviour:
- All outputs are registered.
- Reset values: grant=0, start=0, ack=0, enable_count=0, busy=0, last_winner=NUM_REQ-1 (so port 0 has first priority), timeout_err=0, timer=0, state=IDLE.
- Asserting reset mid-transaction aborts the transaction immediately. No ack or enable_count is produced.
- State IDLE:
  - If halt_signal=1 → HALTED.
  - Else if |req: winner = first set bit scanning from last_winner+1 upward, wrapping modulo NUM_REQ. Register grant[winner]=1, start=1, last_winner=winner, timer=0, then → WAIT.
  - Consequence: grant and start go high on the edge after req is sampled, giving 1-cycle latency.
- State WAIT:
  - start is high only on its first cycle; timer increments each cycle.
  - If match_done=1: capture match_hit → COMMIT.
  - Else if timer==TIMEOUT-1: set timeout_err, hit=0 → COMMIT.
  - match_done takes priority over timeout when both occur in the same cycle.
- State COMMIT (single cycle):
  - ack[winner]=1 and grant cleared on the exit edge.
  - enable_count = hit AND NOT halt_signal.
  - Next state: HALTED if halt_signal=1, else IDLE.
- State HALTED:
  - No grants; all pulse outputs are 0.
  - → IDLE when halt_signal=0, which in practice only happens after reset.
- Pulse and ownership rules:
  - At most one grant bit is ever high.
  - ack and enable_count are never high for more than 1 cycle per transaction.
  - match_done received outside WAIT is ignored.
- Request changes during a transaction:
  - A requester dropping req while granted does not abort; the ack is still issued.
  - A req that is still high after its ack competes again at the lowest priority.
- Minimum transaction length is 3 cycles (IDLE→WAIT→COMMIT), so there is at least 1 idle cycle between back-to-back grants.

Test Plan:
- Reset, then req=4'b0001 with core returning match_done=1/match_hit=1 two cycles after start → grant=0001 and start at cycle 1; ack=0001 and enable_count=1 for 1 cycle each; last_winner=0.
- req=4'b1111 held, every match a hit → grant order 0,1,2,3,0,… and exactly one enable_count per ack.
- Mixed requests: req=4'b1010 with last_winner=1 → grant port 3, then port 1.
- Timeout: never assert match_done → ack pulses after TIMEOUT cycles, enable_count stays 0, timeout_err=1 and remains 1 until reset.
- Miss then halt: match_hit=0 gives ack with no enable_count. Then assert halt_signal during WAIT with a hit → enable_count stays 0, state goes to HALTED, grant stays 0 despite req=4'b1111.
- Reset mid-WAIT → grant, ack and enable_count all 0 immediately; next grant goes to port 0 first.
